alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding an external combinational ALU, with a one-entry registered result stage.
// Optional divide-by-zero flagging is enabled by defining ALU_ISSUE_DIVZ_EN.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [3:0] in_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_carry,
    output logic [3:0] out_sel
`ifdef ALU_ISSUE_DIVZ_EN
    ,
    output logic       out_divz
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Entry layout: {a, b, sel}
    logic [19:0] mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [19:0] head_s;
    logic        empty_s;
    logic        full_s;
    logic        push_s;
    logic        pop_s;
    out_state_e  state_r;
    out_state_e  state_nxt_s;

`ifdef ALU_ISSUE_DIVZ_EN
    function automatic logic is_divz(input logic [3:0] sel, input logic [7:0] b);
        return (sel == 4'b0011) && (b == 8'd0);
    endfunction
`endif

    // FIFO status and head decode; the ALU sees zeros when nothing is queued
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        head_s  = mem_r[rd_ptr_r[AW-1:0]];
        if (empty_s) begin
            alu_a   = 8'd0;
            alu_b   = 8'd0;
            alu_sel = 4'd0;
        end else begin
            alu_a   = head_s[19:12];
            alu_b   = head_s[11:4];
            alu_sel = head_s[3:0];
        end
    end

    assign in_ready  = !full_s;
    assign push_s    = in_valid && !full_s;
    assign out_valid = (state_r == ST_FULL);

    // Output-stage next state and capture decision
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready && !empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (out_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                pop_s       = 1'b0;
            end
        endcase
    end

    // Output-stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_a, in_b, in_sel};
        end
    end

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Result register: captures the ALU response for the head entry as it pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= 8'd0;
            out_carry  <= 1'b0;
            out_sel    <= 4'd0;
`ifdef ALU_ISSUE_DIVZ_EN
            out_divz   <= 1'b0;
`endif
        end else if (pop_s) begin
            out_carry <= alu_carry;
            out_sel   <= head_s[3:0];
`ifdef ALU_ISSUE_DIVZ_EN
            out_divz   <= is_divz(head_s[3:0], head_s[11:4]);
            out_result <= is_divz(head_s[3:0], head_s[11:4]) ? 8'hFF : alu_out;
`else
            out_result <= alu_out;
`endif
        end
    end

endmodule
